sound_sequencer: RTL and testbench

SOUND_SEQUENCER -- requirements
Module: sound_sequencer

---
 rtl/sound_pkg.sv | 27 ++
 rtl/tone_gen.sv | 48 ++++
 rtl/sound_sequencer.sv | 159 +++++++++++++++
 tb/tb_sound_sequencer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types for the sound sequencer: FSM states, sound sources and
// parameter-sizing helpers.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    BUTTON = 2'd1,
    GOOD   = 2'd2,
    BAD    = 2'd3
  } src_t;

  // Pending-bit positions inside the per-source request vector.
  localparam int unsigned PEND_BUTTON = 0;
  localparam int unsigned PEND_GOOD   = 1;
  localparam int unsigned PEND_BAD    = 2;

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_gen.sv
// Half-period square-wave generator. load restarts the wave high with a
// fresh half-period count; enable advances it by one cycle. tone_next is
// the value the toggle register takes at the coming edge, so the parent
// can register it (with muting) without an extra cycle of delay.
module tone_gen #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          nRst,
  input  logic          load,
  input  logic          enable,
  input  logic [CW-1:0] hp,
  output logic          tone_next
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          tone_q;

  // Next counter/toggle value: restart on load, toggle at each half-period.
  always_comb begin
    cnt_d     = cnt_q;
    tone_next = tone_q;
    if (load) begin
      cnt_d     = '0;
      tone_next = 1'b1;
    end else if (enable) begin
      if (cnt_q == hp - CW'(1)) begin
        cnt_d     = '0;
        tone_next = ~tone_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Half-period counter and toggle register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_next;
    end
  end

endmodule

// File: rtl/sound_sequencer.sv
// Game sound sequencer: latches collision/button events as pending
// requests and plays them one at a time, highest priority first, as
// square-wave notes separated by silent gaps. Never preempts a sound.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int unsigned GOOD_HP   = 8,
  parameter int unsigned BAD_HP1   = 12,
  parameter int unsigned BAD_HP2   = 16,
  parameter int unsigned CLICK_HP  = 4,
  parameter int unsigned NOTE_LEN  = 64,
  parameter int unsigned CLICK_LEN = 16,
  parameter int unsigned GAP_LEN   = 8
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       goodColl,
  input  logic       badColl,
  input  logic       button_i,
  input  logic       mute_i,
  output logic       sound_o,
  output logic       busy_o,
  output logic [1:0] src_o
);

  localparam int unsigned MAX_HP  = max2(max2(GOOD_HP, BAD_HP1), max2(BAD_HP2, CLICK_HP));
  localparam int unsigned MAX_LEN = max2(max2(NOTE_LEN, CLICK_LEN), GAP_LEN);
  localparam int unsigned MAXP    = max2(MAX_HP, MAX_LEN);
  localparam int unsigned CW      = $clog2(MAXP + 1);

  state_t        state_q, state_d;
  src_t          src_q, src_d;
  logic          note2_q, note2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pend_q;
  logic [2:0]    grant;
  logic [2:0]    pulses;
  logic [CW-1:0] play_last;
  logic [CW-1:0] cur_hp;
  logic          tone_load;
  logic          tone_en;
  logic          tone_next;
  logic          sound_q;

  assign pulses = {badColl, goodColl, button_i};

  // Note length and half-period of whatever is currently being played.
  always_comb begin
    play_last = CW'(NOTE_LEN - 1);
    cur_hp    = CW'(GOOD_HP);
    case (src_q)
      BUTTON: begin
        play_last = CW'(CLICK_LEN - 1);
        cur_hp    = CW'(CLICK_HP);
      end
      GOOD:    cur_hp = CW'(GOOD_HP);
      BAD:     cur_hp = note2_q ? CW'(BAD_HP2) : CW'(BAD_HP1);
      default: cur_hp = CW'(GOOD_HP);
    endcase
  end

  // Sequencing: priority grant in IDLE, fixed-length PLAY and GAP phases.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    note2_d = note2_q;
    cnt_d   = cnt_q;
    grant   = '0;
    case (state_q)
      IDLE: begin
        cnt_d   = '0;
        note2_d = 1'b0;
        src_d   = NONE;
        if (pend_q[PEND_BAD]) begin
          grant[PEND_BAD] = 1'b1;
          src_d           = BAD;
          state_d         = PLAY;
        end else if (pend_q[PEND_GOOD]) begin
          grant[PEND_GOOD] = 1'b1;
          src_d            = GOOD;
          state_d          = PLAY;
        end else if (pend_q[PEND_BUTTON]) begin
          grant[PEND_BUTTON] = 1'b1;
          src_d              = BUTTON;
          state_d            = PLAY;
        end
      end
      PLAY: begin
        if (cnt_q == play_last) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      GAP: begin
        if (cnt_q == CW'(GAP_LEN - 1)) begin
          cnt_d = '0;
          if (src_q == BAD && !note2_q) begin
            note2_d = 1'b1;
            state_d = PLAY;
          end else begin
            note2_d = 1'b0;
            src_d   = NONE;
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        src_d   = NONE;
        note2_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // The tone restarts on every entry into PLAY and runs only while in PLAY.
  assign tone_load = (state_d == PLAY) && (state_q != PLAY);
  assign tone_en   = (state_d == PLAY) && (state_q == PLAY);

  tone_gen #(
    .CW(CW)
  ) u_tone (
    .clk      (clk),
    .nRst     (nRst),
    .load     (tone_load),
    .enable   (tone_en),
    .hp       (cur_hp),
    .tone_next(tone_next)
  );

  // State, pending requests and the muted speaker drive register.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= IDLE;
      src_q   <= NONE;
      note2_q <= 1'b0;
      cnt_q   <= '0;
      pend_q  <= '0;
      sound_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      note2_q <= note2_d;
      cnt_q   <= cnt_d;
      // A pulse arriving in its own grant cycle re-arms the request.
      pend_q  <= (pend_q & ~grant) | pulses;
      sound_q <= tone_next & (state_d == PLAY) & ~mute_i;
    end
  end

  assign sound_o = sound_q;
  assign busy_o  = (state_q != IDLE);
  assign src_o   = src_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench for sound_sequencer: stimulus pushes time-stamped
// expected output cycles, a negedge monitor pops and compares them.
module tb_sound_sequencer;

  logic       clk = 1'b0;
  logic       nRst;
  logic       goodColl;
  logic       badColl;
  logic       button_i;
  logic       mute_i;
  logic       sound_o;
  logic       busy_o;
  logic [1:0] src_o;

  sound_sequencer #(
    .GOOD_HP  (8),
    .BAD_HP1  (12),
    .BAD_HP2  (16),
    .CLICK_HP (4),
    .NOTE_LEN (64),
    .CLICK_LEN(16),
    .GAP_LEN  (8)
  ) dut (
    .clk     (clk),
    .nRst    (nRst),
    .goodColl(goodColl),
    .badColl (badColl),
    .button_i(button_i),
    .mute_i  (mute_i),
    .sound_o (sound_o),
    .busy_o  (busy_o),
    .src_o   (src_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic       snd;
    logic       bsy;
    logic [1:0] src;
  } exp_t;

  exp_t sb[$];
  int   checks  = 0;
  int   errors  = 0;
  int   mute_lo = -1;
  int   mute_hi = -1;

  task automatic chk(input string name, input int c, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, c, act, exp);
    end
  endtask

  task automatic push(input int c, input logic s, input logic b, input logic [1:0] sr);
    exp_t e;
    e.c   = c;
    e.snd = s;
    e.bsy = b;
    e.src = sr;
    sb.push_back(e);
  endtask

  task automatic sched_idle(input int c, input int n);
    for (int i = 0; i < n; i++) push(c + i, 1'b0, 1'b0, 2'd0);
  endtask

  // One note of half-period h lasting len cycles, then the 8-cycle gap.
  task automatic sched_note(input int s, input int h, input int len, input logic [1:0] sr);
    for (int i = 0; i < len; i++) begin
      logic w;
      w = ((i / h) % 2) == 0;
      if (s + i >= mute_lo && s + i <= mute_hi) w = 1'b0;
      push(s + i, w, 1'b1, sr);
    end
    for (int i = 0; i < 8; i++) push(s + len + i, 1'b0, 1'b1, sr);
  endtask

  // Whole sound for a source starting at cycle s; nxt is the following IDLE cycle.
  task automatic sched_sound(input int s, input logic [1:0] sr, output int nxt);
    case (sr)
      2'd3: begin
        sched_note(s, 12, 64, 2'd3);
        sched_note(s + 72, 16, 64, 2'd3);
        nxt = s + 144;
      end
      2'd2: begin
        sched_note(s, 8, 64, 2'd2);
        nxt = s + 72;
      end
      default: begin
        sched_note(s, 4, 16, 2'd1);
        nxt = s + 24;
      end
    endcase
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) next_cycle();
  endtask

  // Monitor: compare every cycle that has a scheduled expectation.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].c <= cyc) begin
      e = sb.pop_front();
      if (e.c < cyc) begin
        chk("stale_entry", e.c, 2'(cyc - e.c), 2'd0);
      end else begin
        chk("sound_o", cyc, {1'b0, sound_o}, {1'b0, e.snd});
        chk("busy_o", cyc, {1'b0, busy_o}, {1'b0, e.bsy});
        chk("src_o", cyc, src_o, e.src);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n, n1, n2, n3, r;
    nRst     = 1'b0;
    goodColl = 1'b0;
    badColl  = 1'b0;
    button_i = 1'b0;
    mute_i   = 1'b0;
    repeat (2) next_cycle();
    chk("rst_sound", cyc, {1'b0, sound_o}, 2'd0);
    chk("rst_busy", cyc, {1'b0, busy_o}, 2'd0);
    chk("rst_src", cyc, src_o, 2'd0);
    nRst = 1'b1;
    next_cycle();
    sched_idle(cyc, 2);
    next_cycle();
    next_cycle();

    // Single good collision: sound at t+2, idle again at t+74.
    t = cyc;
    goodColl = 1'b1;
    sched_idle(t, 2);
    sched_sound(t + 2, 2'd2, n);
    sched_idle(n, 4);
    next_cycle();
    goodColl = 1'b0;
    wait_to(n + 4);

    // Bad collision: two notes with a gap, src 3 throughout.
    t = cyc;
    badColl = 1'b1;
    sched_idle(t, 2);
    sched_sound(t + 2, 2'd3, n);
    sched_idle(n, 4);
    next_cycle();
    badColl = 1'b0;
    wait_to(n + 4);

    // All three in one cycle: bad, then good, then button, one IDLE cycle between.
    t = cyc;
    goodColl = 1'b1;
    badColl  = 1'b1;
    button_i = 1'b1;
    sched_idle(t, 2);
    sched_sound(t + 2, 2'd3, n1);
    sched_idle(n1, 1);
    sched_sound(n1 + 1, 2'd2, n2);
    sched_idle(n2, 1);
    sched_sound(n2 + 1, 2'd1, n3);
    sched_idle(n3, 4);
    next_cycle();
    goodColl = 1'b0;
    badColl  = 1'b0;
    button_i = 1'b0;
    wait_to(n3 + 4);

    // Button during a good note waits for the good note and its gap.
    t = cyc;
    goodColl = 1'b1;
    sched_idle(t, 2);
    sched_sound(t + 2, 2'd2, n);
    sched_idle(n, 1);
    sched_sound(n + 1, 2'd1, n2);
    sched_idle(n2, 4);
    next_cycle();
    goodColl = 1'b0;
    wait_to(t + 20);
    button_i = 1'b1;
    next_cycle();
    button_i = 1'b0;
    wait_to(n2 + 4);

    // Mute mid-note silences output only; waveform phase continues.
    t = cyc;
    mute_lo = t + 11;
    mute_hi = t + 30;
    goodColl = 1'b1;
    sched_idle(t, 2);
    sched_sound(t + 2, 2'd2, n);
    sched_idle(n, 4);
    mute_lo = -1;
    mute_hi = -1;
    next_cycle();
    goodColl = 1'b0;
    wait_to(t + 10);
    mute_i = 1'b1;
    wait_to(t + 30);
    mute_i = 1'b0;
    wait_to(n + 4);

    // Re-pulse in the grant cycle keeps the request: good plays twice.
    t = cyc;
    goodColl = 1'b1;
    sched_idle(t, 2);
    sched_sound(t + 2, 2'd2, n);
    sched_idle(n, 1);
    sched_sound(n + 1, 2'd2, n2);
    sched_idle(n2, 4);
    next_cycle();
    next_cycle();
    goodColl = 1'b0;
    wait_to(n2 + 4);

    // Reset mid bad note with good pending: everything discarded.
    t = cyc;
    badColl = 1'b1;
    sched_idle(t, 2);
    for (int i = 0; i < 38; i++) push(t + 2 + i, ((i / 12) % 2) == 0, 1'b1, 2'd3);
    next_cycle();
    badColl = 1'b0;
    wait_to(t + 10);
    goodColl = 1'b1;
    next_cycle();
    goodColl = 1'b0;
    wait_to(t + 40);
    nRst = 1'b0;
    #1;
    chk("midrst_sound", cyc, {1'b0, sound_o}, 2'd0);
    chk("midrst_busy", cyc, {1'b0, busy_o}, 2'd0);
    chk("midrst_src", cyc, src_o, 2'd0);
    wait_to(t + 43);
    nRst = 1'b1;
    r = cyc;
    sched_idle(r, 200);
    wait_to(r + 201);

    chk("sb_empty", cyc, {1'b0, sb.size() == 0}, 2'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
